keypress_driver: RTL and testbench
==================================

Name: keypress_driver

Overview:
Generates clean key-level waveforms for the keypress release-detector input, acting as the "computer player" or test stimulus side of the tug-of-war key interface. Each one-cycle press request becomes exactly one high pulse of fixed length, followed by a mandatory low gap, so the downstream detector emits exactly one release pulse per request. Requests that arrive while a press is in progress are queued in a saturating pending counter. Requests that arrive when that counter is full are dropped and flagged.

Parameters:
HOLD_CYCLES, 3, number of cycles key_out is held high per press (must be >= 1)
GAP_CYCLES, 2, minimum number of low cycles after each press (must be >= 1, so the detector sees a release)
MAX_PENDING, 7, saturation limit of the pending-request counter (must be >= 1)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
req  in  1  press request; each sampled-high cycle counts as one request
key_out  out  1  key level to the keypress detector input; decoded only from the state register, with no combinational path from req
busy  out  1  high when state != IDLE or pending != 0
pending  out  $clog2(MAX_PENDING+1)  number of queued, not-yet-launched presses
overflow  out  1  one-cycle pulse when a request is dropped

Behaviour:
- Reset (sampled at posedge): state=IDLE, timer=0, pending=0, key_out=0, busy=0, overflow=0. Reset mid-press abandons the press immediately: key_out is low in the cycle after the reset edge, and all queued requests are discarded.
- States: IDLE, HOLD, GAP. key_out = (state==HOLD).
- Launch condition: launch = (req || pending!=0) && (state==IDLE || (state==GAP && timer==0)).
- On launch: state<=HOLD, timer<=HOLD_CYCLES-1.
- HOLD: timer decrements each cycle. When timer==0: state<=GAP, timer<=GAP_CYCLES-1.
- GAP: timer decrements each cycle. When timer==0 and no launch: state<=IDLE.
- Latency: req sampled high at edge k in IDLE gives key_out high for cycles k+1 .. k+HOLD_CYCLES, then low for at least GAP_CYCLES cycles.
- Back-to-back launches give a period of exactly HOLD_CYCLES+GAP_CYCLES (5 with defaults). There is never an idle cycle between queued presses.
- Pending counter update: pending_next = pending + accept - (launch && pending!=0).
  - accept = req && !(launch && pending==0), i.e. a request consumed directly by the launch is never queued.
  - A request that arrives while pending==MAX_PENDING is accepted only if the same cycle launches from the queue (net count unchanged). Otherwise it is dropped, and overflow=1 on the next cycle.
- Simultaneous events:
  - req coinciding with the final GAP cycle while pending==0: the request launches directly and pending stays 0.
  - req while in HOLD: queued (pending+1).
- overflow is registered: it is high for exactly one cycle per dropped request.
- Width rule: timer width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)). The counter must never wrap.
- Elaboration check: $error if HOLD_CYCLES<1, GAP_CYCLES<1 or MAX_PENDING<1.

Decomposition:
- Shared package tug_pkg holds:
  - typedef enum logic [1:0] {DRV_IDLE, DRV_HOLD, DRV_GAP} drv_state_t;
  - default timing constants KEY_HOLD_CYCLES=3 and KEY_GAP_CYCLES=2, reused by the player/computer logic.
- One sub-module, phase_timer: a loadable down-counter with inputs load, load_val and en, and outputs count and zero. keypress_driver instantiates it for the HOLD/GAP timing.
- The FSM and the pending counter stay inline in keypress_driver.

Test Plan:
- Reset, then a single req at cycle 2 -> key_out high cycles 3-5 and low cycles 6-7, state IDLE at cycle 8, pending=0, busy low from cycle 8.
- req on 3 consecutive cycles from IDLE -> pending peaks at 2. Three presses with key_out rising at cycles t, t+5 and t+10, each exactly 3 cycles high. A chained keypress detector emits exactly 3 single-cycle pulses.
- Hold req high for 12 cycles -> pending saturates at 7, overflow pulses on each dropped request, and the total number of launched presses equals 1 + accepted requests.
- req on the final GAP cycle with pending=0 -> the next HOLD starts on the following cycle, pending never leaves 0, and the period is 5.
- Reset asserted in the 2nd HOLD cycle with pending=3 -> next cycle key_out=0, pending=0, busy=0, overflow=0. A new req afterwards produces a normal 3-high/2-low press.
- Parameter override HOLD_CYCLES=1, GAP_CYCLES=1, MAX_PENDING=1 -> alternating 1-high/1-low waveform under continuous req, with overflow asserting on every second request.

Source files
------------

// File: rtl/keypress_driver_pkg.sv
// tug_pkg: shared state encoding and key timing defaults for the tug-of-war key drivers.
package tug_pkg;
  typedef enum logic [1:0] {DRV_IDLE, DRV_HOLD, DRV_GAP} drv_state_t;
  localparam int KEY_HOLD_CYCLES = 3;
  localparam int KEY_GAP_CYCLES = 2;
  function automatic int max_i(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/keypress_driver_if.sv
// keypress_driver_if: request/key-level bundle between a press requester and the key driver.
interface keypress_driver_if #(parameter int MAX_PENDING = 7);
  localparam int PW = $clog2(MAX_PENDING + 1);
  logic          req;
  logic          key_out;
  logic          busy;
  logic [PW-1:0] pending;
  logic          overflow;
  modport master (output req, input key_out, busy, pending, overflow);
  modport slave (input req, output key_out, busy, pending, overflow);
endinterface

// File: rtl/keypress_driver_phase_timer.sv
// phase_timer: loadable down-counter that stops at zero, timing the HOLD and GAP phases.
module phase_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         zero
);
  logic [W-1:0] count_q, count_d;
  always_comb count_d = load ? load_val : (en && count_q != '0) ? count_q - W'(1) : count_q;
  always_ff @(posedge clk) count_q <= reset ? '0 : count_d;
  assign count = count_q;
  assign zero  = count_q == '0;
endmodule

// File: rtl/keypress_driver.sv
// keypress_driver: turns one-cycle press requests into fixed high pulses with a mandatory low gap,
// queueing requests that arrive mid-press in a saturating counter.
module keypress_driver
  import tug_pkg::*;
#(
  parameter int HOLD_CYCLES = KEY_HOLD_CYCLES,
  parameter int GAP_CYCLES  = KEY_GAP_CYCLES,
  parameter int MAX_PENDING = 7
) (
  input logic clk,
  input logic reset,
  keypress_driver_if.slave drv
);
  localparam int TW = max_i(1, $clog2(max_i(HOLD_CYCLES, GAP_CYCLES)));
  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PENDING);
  if (HOLD_CYCLES < 1 || GAP_CYCLES < 1 || MAX_PENDING < 1) begin : g_param_chk
    $error("keypress_driver: HOLD_CYCLES, GAP_CYCLES and MAX_PENDING must all be >= 1");
  end
  drv_state_t    state_q, state_d;
  logic [PW-1:0] pend_q, pend_d;
  logic          ovf_q, ovf_d;
  logic [TW-1:0] t_count;
  logic          t_zero, hold_end, gap_end, launch, from_q, accept, drop;
  assign hold_end = state_q == DRV_HOLD && t_count == '0;
  assign gap_end  = state_q == DRV_GAP && t_zero;
  assign launch   = (drv.req || pend_q != '0) && (state_q == DRV_IDLE || gap_end);
  assign from_q   = launch && pend_q != '0;
  // A request that launches straight from an empty queue is consumed, never counted.
  assign accept   = drv.req && !(launch && pend_q == '0);
  assign drop     = accept && pend_q == PEND_MAX && !from_q;
  always_comb begin
    state_d = launch ? DRV_HOLD : hold_end ? DRV_GAP : gap_end ? DRV_IDLE : state_q;
    pend_d  = pend_q + PW'(accept && !drop) - PW'(from_q);
    ovf_d   = drop;
  end
  always_ff @(posedge clk) begin
    state_q <= reset ? DRV_IDLE : state_d;
    pend_q  <= reset ? '0 : pend_d;
    ovf_q   <= reset ? 1'b0 : ovf_d;
  end
  phase_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (launch || hold_end),
    .load_val (launch ? HOLD_LD : GAP_LD),
    .en       (state_q != DRV_IDLE),
    .count    (t_count),
    .zero     (t_zero)
  );
  assign drv.key_out  = state_q == DRV_HOLD;
  assign drv.busy     = state_q != DRV_IDLE || pend_q != '0;
  assign drv.pending  = pend_q;
  assign drv.overflow = ovf_q;
endmodule

// File: tb/tb_keypress_driver.sv
// tb_keypress_driver: drives a default and a minimal-parameter driver side by side against a slot-based press model.
module tb_keypress_driver;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  keypress_driver_if #(.MAX_PENDING(7)) ia ();
  keypress_driver_if #(.MAX_PENDING(1)) ib ();
  keypress_driver #(.HOLD_CYCLES(3), .GAP_CYCLES(2), .MAX_PENDING(7)) dut_a (.clk(clk), .reset(reset), .drv(ia));
  keypress_driver #(.HOLD_CYCLES(1), .GAP_CYCLES(1), .MAX_PENDING(1)) dut_b (.clk(clk), .reset(reset), .drv(ib));
  int total = 0;
  int bad = 0;
  int hh[2] = '{3, 1};
  int gg[2] = '{2, 1};
  int mm[2] = '{7, 1};
  int nxt[2] = '{0, 0};
  int last[2] = '{0, 0};
  int pend[2] = '{0, 0};
  int launches[2] = '{0, 0};
  int falls[2] = '{0, 0};
  bit has[2] = '{0, 0};
  bit ovf[2] = '{0, 0};
  logic prev_key[2] = '{1'b0, 1'b0};
  int e = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0d want %0d (edge %0d)", tag, obs, exp, e);
    end
  endtask
  // One clock: edge e samples the inputs; a press launched at edge L is high after edges L..L+H-1
  // and the next press may launch no earlier than edge L+H+G.
  task automatic step(input logic rst, input logic ra, input logic rb);
    logic r[2];
    logic k;
    r[0] = ra;
    r[1] = rb;
    reset = rst;
    ia.req = ra;
    ib.req = rb;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      ovf[i] = 1'b0;
      if (rst) begin
        nxt[i] = e + 1;
        has[i] = 1'b0;
        pend[i] = 0;
      end else if (e >= nxt[i] && (r[i] || pend[i] > 0)) begin
        launches[i]++;
        has[i] = 1'b1;
        last[i] = e;
        nxt[i] = e + hh[i] + gg[i];
        if (pend[i] > 0) pend[i] = pend[i] - 1 + int'(r[i]);
      end else if (r[i]) begin
        if (pend[i] < mm[i]) pend[i]++;
        else ovf[i] = 1'b1;
      end
    end
    #1;
    chk("key_a", 32'(ia.key_out), 32'(has[0] && e - last[0] < hh[0]));
    chk("pend_a", 32'(ia.pending), 32'(pend[0]));
    chk("busy_a", 32'(ia.busy), 32'((has[0] && e <= last[0] + hh[0] + gg[0] - 1) || pend[0] > 0));
    chk("ovf_a", 32'(ia.overflow), 32'(ovf[0]));
    chk("key_b", 32'(ib.key_out), 32'(has[1] && e - last[1] < hh[1]));
    chk("pend_b", 32'(ib.pending), 32'(pend[1]));
    chk("busy_b", 32'(ib.busy), 32'((has[1] && e <= last[1] + hh[1] + gg[1] - 1) || pend[1] > 0));
    chk("ovf_b", 32'(ib.overflow), 32'(ovf[1]));
    for (int i = 0; i < 2; i++) begin
      k = i == 0 ? ia.key_out : ib.key_out;
      if (prev_key[i] === 1'b1 && k === 1'b0) falls[i]++;
      prev_key[i] = k;
    end
    e++;
  endtask
  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask
  initial begin
    ia.req = 1'b0;
    ib.req = 1'b0;
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b1);
    idle(8);
    repeat (3) step(1'b0, 1'b1, 1'b1);
    idle(20);
    repeat (12) step(1'b0, 1'b1, 1'b1);
    idle(60);
    step(1'b0, 1'b1, 1'b1);
    idle(4);
    step(1'b0, 1'b1, 1'b0);
    idle(10);
    repeat (4) step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0);
    idle(8);
    repeat (12) step(1'b0, 1'b0, 1'b1);
    idle(4);
    repeat (400) step($urandom_range(0, 99) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    repeat (100) step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    idle(60);
    chk("falls_a", 32'(falls[0]), 32'(launches[0]));
    chk("falls_b", 32'(falls[1]), 32'(launches[1]));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
